// File: rtl/potential_adder_pkg.sv
// Shared types and constants for the potential adder: FSM encoding, default
// widths and the saturation limits of the default-width datapath.
package potential_adder_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPARE = 2'd1,
    ST_WRITE   = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  localparam logic [DEF_WIDTH-1:0] DEF_SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] DEF_SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/potential_adder_sat_add.sv
// Signed two's-complement adder that clamps to the most positive / most
// negative representable value instead of wrapping.
module sat_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] raw_sum;
  logic             overflow;

  assign raw_sum = a_i + b_i;
  // Overflow only when both operands share a sign that the result lost.
  assign overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw_sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    sum_o = raw_sum;
    if (overflow) begin
      sum_o = a_i[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/potential_adder.sv
// Accumulates synaptic weights per time step, adds the decayed membrane
// potential, fires against a threshold and writes the result back to decay.
module potential_adder
  import potential_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             time_step,
  input  logic [WIDTH-1:0] decayed_potential,
  input  logic [WIDTH-1:0] weight_in,
  input  logic             weight_valid,
  output logic             weight_ready,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] v_reset,
  output logic [WIDTH-1:0] new_potential,
  output logic             load,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count,
  output logic             missed_step
);

  state_e           state_q, state_d;
  logic             ts_q;
  logic             ts_edge;
  logic             weight_take;
  logic             fire;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] total;
  logic [WIDTH-1:0] new_pot_q;
  logic             load_q;
  logic             spike_q;
  logic [CNT_W-1:0] cnt_q;
  logic             missed_q;

  assign ts_edge     = time_step & ~ts_q;
  assign weight_take = weight_valid & weight_ready;

  sat_add #(.WIDTH(WIDTH)) u_acc_add (
    .a_i  (acc_q),
    .b_i  (weight_in),
    .sum_o(acc_sum)
  );

  sat_add #(.WIDTH(WIDTH)) u_total_add (
    .a_i  (decayed_potential),
    .b_i  (acc_q),
    .sum_o(total)
  );

  assign fire = $signed(total) >= $signed(threshold);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM:   if (ts_edge) state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_ACCUM;
      default:    state_d = ST_ACCUM;
    endcase
  end

  // Ready is gated by reset directly so it reads 0 while reset is held.
  always_comb begin
    weight_ready = rst && (state_q == ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q      <= 1'b0;
      acc_q     <= '0;
      new_pot_q <= '0;
      load_q    <= 1'b0;
      spike_q   <= 1'b0;
      cnt_q     <= '0;
      missed_q  <= 1'b0;
    end else begin
      ts_q <= time_step;
      if (ts_edge && (state_q != ST_ACCUM)) begin
        missed_q <= 1'b1;
      end
      unique case (state_q)
        ST_ACCUM: begin
          if (weight_take) begin
            acc_q <= acc_sum;
          end
        end
        ST_COMPARE: begin
          spike_q   <= fire;
          new_pot_q <= fire ? v_reset : total;
          load_q    <= 1'b1;
        end
        ST_WRITE: begin
          acc_q   <= '0;
          load_q  <= 1'b0;
          spike_q <= 1'b0;
          if (spike_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          load_q  <= 1'b0;
          spike_q <= 1'b0;
        end
      endcase
    end
  end

  assign new_potential = new_pot_q;
  assign load          = load_q;
  assign spike         = spike_q;
  assign spike_count   = cnt_q;
  assign missed_step   = missed_q;

endmodule

// File: tb/tb_potential_adder.sv
// Directed bench for potential_adder: hand-computed vectors, one line per step.
module tb_potential_adder;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             time_step;
  logic [WIDTH-1:0] decayed_potential;
  logic [WIDTH-1:0] weight_in;
  logic             weight_valid;
  logic             weight_ready;
  logic [WIDTH-1:0] threshold;
  logic [WIDTH-1:0] v_reset;
  logic [WIDTH-1:0] new_potential;
  logic             load;
  logic             spike;
  logic [CNT_W-1:0] spike_count;
  logic             missed_step;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  potential_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .time_step        (time_step),
    .decayed_potential(decayed_potential),
    .weight_in        (weight_in),
    .weight_valid     (weight_valid),
    .weight_ready     (weight_ready),
    .threshold        (threshold),
    .v_reset          (v_reset),
    .new_potential    (new_potential),
    .load             (load),
    .spike            (spike),
    .spike_count      (spike_count),
    .missed_step      (missed_step)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the weight is taken on the next rising edge.
  task automatic send_weight(input logic [31:0] w);
    weight_in    = w;
    weight_valid = 1'b1;
    @(negedge clk);
    weight_valid = 1'b0;
  endtask

  task automatic do_step(input string tag, input logic [31:0] dec, input logic with_w,
                         input logic [31:0] w, input logic [31:0] exp_np,
                         input logic exp_sp, input logic [1:0] exp_cnt);
    decayed_potential = dec;
    time_step         = 1'b1;
    weight_valid      = with_w;
    weight_in         = w;
    @(negedge clk);
    time_step    = 1'b0;
    weight_valid = 1'b0;
    check({tag, "_cmp_load"}, 64'(load), 64'd0);
    check({tag, "_cmp_ready"}, 64'(weight_ready), 64'd0);
    @(negedge clk);
    check({tag, "_wr_load"}, 64'(load), 64'd1);
    check({tag, "_wr_spike"}, 64'(spike), 64'(exp_sp));
    check({tag, "_wr_newpot"}, 64'(new_potential), 64'(exp_np));
    @(negedge clk);
    check({tag, "_post_load"}, 64'(load), 64'd0);
    check({tag, "_post_spike"}, 64'(spike), 64'd0);
    check({tag, "_post_newpot"}, 64'(new_potential), 64'(exp_np));
    check({tag, "_post_count"}, 64'(spike_count), 64'(exp_cnt));
    check({tag, "_post_ready"}, 64'(weight_ready), 64'd1);
    $display("step %s: decayed=%0h new_potential=%0h spike_count=%0d", tag, dec, new_potential, spike_count);
  endtask

  initial begin
    int loads;
    rst               = 1'b0;
    time_step         = 1'b0;
    decayed_potential = '0;
    weight_in         = '0;
    weight_valid      = 1'b0;
    threshold         = 32'd1000;
    v_reset           = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_newpot", 64'(new_potential), 64'd0);
    check("rst_load", 64'(load), 64'd0);
    check("rst_spike", 64'(spike), 64'd0);
    check("rst_count", 64'(spike_count), 64'd0);
    check("rst_missed", 64'(missed_step), 64'd0);
    check("rst_ready", 64'(weight_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("rel_ready", 64'(weight_ready), 64'd1);
    @(negedge clk);

    // 900 + 50 + 30 = 980 < 1000
    send_weight(32'd50);
    send_weight(32'd30);
    do_step("below", 32'd900, 1'b0, 32'd0, 32'd980, 1'b0, 2'd0);

    // 900 + 100 = 1000 >= 1000 fires; next step starts from acc=0
    send_weight(32'd100);
    do_step("fire", 32'd900, 1'b0, 32'd0, 32'd0, 1'b1, 2'd1);
    do_step("acc_clr", 32'd900, 1'b0, 32'd0, 32'd900, 1'b0, 2'd1);

    // Positive saturation: total clamps to MAX, which meets threshold MAX
    threshold = 32'h7FFF_FFFF;
    send_weight(32'h0000_1000);
    do_step("sat_pos", 32'h7FFF_FF00, 1'b0, 32'd0, 32'd0, 1'b1, 2'd2);
    threshold = 32'd1000;
    // Negative saturation: two MIN weights stay at MIN instead of wrapping to 0
    send_weight(32'h8000_0000);
    send_weight(32'h8000_0000);
    do_step("sat_neg", 32'd0, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 2'd2);

    // Weight presented on the detecting edge belongs to this step
    do_step("same_edge", 32'd900, 1'b1, 32'd100, 32'd0, 1'b1, 2'd3);

    // Weight offered during COMPARE waits for the first ACCUM cycle
    decayed_potential = 32'd900;
    time_step         = 1'b1;
    @(negedge clk);
    time_step    = 1'b0;
    weight_in    = 32'd7;
    weight_valid = 1'b1;
    check("pend_cmp_ready", 64'(weight_ready), 64'd0);
    @(negedge clk);
    check("pend_wr_ready", 64'(weight_ready), 64'd0);
    check("pend_wr_newpot", 64'(new_potential), 64'd900);
    @(negedge clk);
    check("pend_acc_ready", 64'(weight_ready), 64'd1);
    @(negedge clk);
    weight_valid = 1'b0;
    do_step("pend", 32'd0, 1'b0, 32'd0, 32'd7, 1'b0, 2'd3);

    // spike_count saturates at all-ones
    do_step("cnt_sat", 32'd900, 1'b1, 32'd100, 32'd0, 1'b1, 2'd3);

    // time_step edge during WRITE is dropped and flagged
    decayed_potential = 32'd900;
    time_step         = 1'b1;
    @(negedge clk);
    time_step = 1'b0;
    @(negedge clk);
    check("miss_wr_load", 64'(load), 64'd1);
    time_step = 1'b1;
    @(negedge clk);
    time_step = 1'b0;
    check("miss_flag", 64'(missed_step), 64'd1);
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (load) loads++;
    end
    check("miss_no_load", 64'(loads), 64'd0);
    check("miss_sticky", 64'(missed_step), 64'd1);
    $display("step missed: missed_step=%0d extra_loads=%0d", missed_step, loads);

    // Reset in COMPARE aborts the step
    decayed_potential = 32'd2000;
    time_step         = 1'b1;
    @(negedge clk);
    time_step = 1'b0;
    rst       = 1'b0;
    #1;
    check("abort_newpot", 64'(new_potential), 64'd0);
    check("abort_count", 64'(spike_count), 64'd0);
    check("abort_missed", 64'(missed_step), 64'd0);
    check("abort_ready", 64'(weight_ready), 64'd0);
    loads = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (load || spike) loads++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (load || spike) loads++;
    end
    check("abort_no_pulse", 64'(loads), 64'd0);
    check("abort_ready_after", 64'(weight_ready), 64'd1);
    $display("step abort: pulses=%0d spike_count=%0d", loads, spike_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/potential_adder.md
POTENTIAL_ADDER -- requirements
Module: potential_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: potential and weight width, signed two's complement.
REQ-002 SHALL have parameter CNT_W, default 16: spike_count width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port time_step  input  1: time-step strobe, shared with potential_decay.
REQ-006 SHALL have port decayed_potential  input  WIDTH: potential_decay output_potential_decay.
REQ-007 SHALL have port weight_in  input  WIDTH: signed synaptic weight.
REQ-008 SHALL have port weight_valid  input  1: weight_in valid.
REQ-009 SHALL have port weight_ready  output  1: weight can be accepted.
REQ-010 SHALL have port threshold  input  WIDTH: signed firing threshold.
REQ-011 SHALL have port v_reset  input  WIDTH: post-spike potential.
REQ-012 SHALL have port new_potential  output  WIDTH: value to potential_decay new_potential.
REQ-013 SHALL have port load  output  1: potential_decay load strobe.
REQ-014 SHALL have port spike  output  1: one-cycle spike pulse.
REQ-015 SHALL have port spike_count  output  CNT_W: spikes since reset.
REQ-016 SHALL have port missed_step  output  1: sticky flag for an ignored time_step edge.

Function
REQ-017 SHALL detect a time_step rising edge as time_step=1 at a clock edge with the registered previous sample =0.
REQ-018 SHALL implement FSM ACCUM -> COMPARE -> WRITE -> ACCUM; ACCUM is the reset state.
REQ-019 SHALL drive weight_ready=1 only in ACCUM with rst high; weight_ready SHALL be 0 in COMPARE and WRITE.
REQ-020 In ACCUM, a weight SHALL be accepted when weight_valid&&weight_ready: acc <= sat(acc+weight_in).
REQ-021 In ACCUM, on a time_step edge the FSM SHALL go to COMPARE; a weight accepted on that same edge SHALL count toward the current step.
REQ-022 In COMPARE, total SHALL be sat(decayed_potential+acc).
REQ-023 In COMPARE, the next edge SHALL set spike=(total>=threshold, signed) and new_potential=(spike ? v_reset : total), set load=1, and move to WRITE.
REQ-024 load and spike SHALL be high for exactly the one WRITE cycle; new_potential SHALL hold its value until the next WRITE.
REQ-025 Latency: load and spike SHALL be high in the second cycle after the edge that detects time_step.
REQ-026 The WRITE exit edge SHALL clear acc to 0, drop load and spike, increment spike_count if spike, and return to ACCUM.
REQ-027 spike_count SHALL saturate at all-ones, with no wrap.
REQ-028 sat() SHALL clamp to 2^(WIDTH-1)-1 / -2^(WIDTH-1) on signed overflow.
REQ-029 A time_step edge seen in COMPARE or WRITE SHALL be ignored and SHALL set missed_step; missed_step clears only on reset.
REQ-030 A weight held valid while weight_ready=0 SHALL stay pending and be accepted in the first ACCUM cycle.

Reset
REQ-031 While rst=0: state=ACCUM, acc=0, time_step sample=0, new_potential=0, load=0, spike=0, spike_count=0, missed_step=0, weight_ready=0.
REQ-032 Reset asserted mid-COMPARE or mid-WRITE SHALL abort the step immediately, with no load or spike pulse produced.

Structure
REQ-033 A shared package SHALL hold the FSM state encodings, the default WIDTH/CNT_W, and the MAX/MIN saturation constants.
REQ-034 A sub-module sat_add (WIDTH-parameterised signed saturating adder) SHALL be used for both additions.

Verification (threshold=1000, v_reset=0 unless stated)
REQ-035 Scenario: reset -> all outputs 0; after release weight_ready=1.
REQ-036 Scenario: decayed=900, weights 50 and 30, then time_step -> new_potential=980, spike=0, load one cycle, 2 cycles after detection.
REQ-037 Scenario: decayed=900, weight 100, time_step -> spike=1 one cycle, new_potential=0, spike_count=1; next step acc starts at 0.
REQ-038 Scenario: decayed=0x7FFFFF00, weight 0x00001000, threshold=0x7FFFFFFF -> total=0x7FFFFFFF, spike=1; two weights 0x80000000 -> acc=0x80000000, no wrap.
REQ-039 Scenario: weight_valid on the edge detecting time_step -> weight included; weight offered during COMPARE -> ready=0, accepted first ACCUM cycle.
REQ-040 Scenario: time_step edge during WRITE -> missed_step=1, no extra load; rst=0 during COMPARE -> load never pulses, all outputs 0.
